// File: rtl/wbuf_drain_if.sv
// ---------------------------------------------------------------------------
// wbuf_drain_if
//   Bundle of the handshake/bus signals around the store-buffer drain engine.
//   The signal names keep the engine's point of view: *_i are driven into the
//   engine, *_o are driven by it.
//
//   FIFO side : Empty_i, ReadData_i {strb,addr,data}, Read_o (pop pulse)
//   Control   : Hold_i, FlushReq_i, FlushDone_o, Busy_o, Error_o
//   Memory    : MemValid_o, MemAddr_o, MemWData_o, MemWStrb_o, MemReady_i
//
//   master : the drain engine
//   slave  : the environment (FIFO, memory port, cache control)
// ---------------------------------------------------------------------------
interface wbuf_drain_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int W_STRB = 4
) ();
  localparam int W_ENTRY = W_STRB + W_ADDR + W_DATA;

  // FIFO side
  logic               Empty_i;
  logic [W_ENTRY-1:0] ReadData_i;
  logic               Read_o;
  // control / status
  logic               Hold_i;
  logic               FlushReq_i;
  logic               FlushDone_o;
  logic               Busy_o;
  logic               Error_o;
  // memory write port
  logic               MemValid_o;
  logic [W_ADDR-1:0]  MemAddr_o;
  logic [W_DATA-1:0]  MemWData_o;
  logic [W_STRB-1:0]  MemWStrb_o;
  logic               MemReady_i;

  modport master (
    input  Empty_i, ReadData_i, Hold_i, FlushReq_i, MemReady_i,
    output Read_o, FlushDone_o, Busy_o, Error_o,
           MemValid_o, MemAddr_o, MemWData_o, MemWStrb_o
  );

  modport slave (
    output Empty_i, ReadData_i, Hold_i, FlushReq_i, MemReady_i,
    input  Read_o, FlushDone_o, Busy_o, Error_o,
           MemValid_o, MemAddr_o, MemWData_o, MemWStrb_o
  );
endinterface

// File: rtl/wbuf_drain_ctrl.sv
// ---------------------------------------------------------------------------
// wbuf_drain_ctrl
//   Store-buffer drain engine. Takes the head entry of the write FIFO, issues
//   it as a single memory write (valid/ready) and pops it only after the
//   memory has acked, so the entry stays visible to the FIFO address-compare
//   logic until memory owns it. Supports hold (read-miss priority), flush to
//   empty and a sticky write-ack timeout flag.
//
//   Ports
//     sClk_i  : clock, all state on the rising edge
//     sRst_i  : asynchronous reset, active high
//     bus     : wbuf_drain_if.master (FIFO head/pop, hold/flush control,
//               memory write request, busy/error status)
//
//   Parameters
//     W_ADDR/W_DATA/W_STRB : memory write widths; FIFO entry is
//                            {strb, addr, data} with data at the LSBs
//     C_TIMEOUT            : unacked ISSUE cycles before Error_o; 0 disables
// ---------------------------------------------------------------------------
module wbuf_drain_ctrl #(
  parameter int W_ADDR    = 32,
  parameter int W_DATA    = 32,
  parameter int W_STRB    = 4,
  parameter int C_TIMEOUT = 255
) (
  input  logic          sClk_i,
  input  logic          sRst_i,
  wbuf_drain_if.master  bus
);

  localparam int W_ENTRY = W_STRB + W_ADDR + W_DATA;
  // A zero-width counter is not legal, keep one bit when the timeout is off.
  localparam int W_CNT   = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
  localparam logic [W_CNT-1:0] CNT_MAX = W_CNT'(C_TIMEOUT);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_POP   = 2'd2;

  typedef struct packed {
    logic [W_STRB-1:0] strb;
    logic [W_ADDR-1:0] addr;
    logic [W_DATA-1:0] data;
  } entry_t;

  logic [1:0]       state;
  entry_t           head;
  entry_t           req_q;
  logic [W_CNT-1:0] to_cnt;
  logic             err_q;
  logic             start;
  logic             ack;

  assign head = entry_t'(bus.ReadData_i);

  // Flush overrides hold; an empty FIFO never starts a write.
  assign start = ~bus.Empty_i & (~bus.Hold_i | bus.FlushReq_i);

  // Valid is decoded from state so an async reset drops it immediately.
  assign ack   = (state == S_ISSUE) & bus.MemReady_i;

  always_ff @(posedge sClk_i or posedge sRst_i) begin
    if (sRst_i) begin
      state  <= S_IDLE;
      req_q  <= '0;
      to_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            req_q <= head;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Hold has no effect here; the write waits for its ack forever.
          if (ack) begin
            state <= S_POP;
          end else if ((C_TIMEOUT > 0) && (to_cnt != CNT_MAX)) begin
            to_cnt <= to_cnt + W_CNT'(1);
          end
        end
        S_POP: begin
          // Back to IDLE so Empty_i is re-sampled after the FIFO has popped.
          to_cnt <= '0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky: the flag registers one edge after the counter reaches the limit.
  always_ff @(posedge sClk_i or posedge sRst_i) begin
    if (sRst_i)
      err_q <= 1'b0;
    else if ((C_TIMEOUT > 0) && (to_cnt == CNT_MAX))
      err_q <= 1'b1;
  end

  assign bus.MemValid_o  = (state == S_ISSUE);
  assign bus.Read_o      = (state == S_POP);
  assign bus.Busy_o      = (state != S_IDLE);
  assign bus.FlushDone_o = bus.FlushReq_i & (state == S_IDLE) & bus.Empty_i;
  assign bus.Error_o     = err_q;
  assign bus.MemAddr_o   = req_q.addr;
  assign bus.MemWData_o  = req_q.data;
  assign bus.MemWStrb_o  = req_q.strb;

endmodule
